alu_arbiter: RTL

//  Shares one ALU instance (3-bit control: 000 and, 001 xor, 010 sll, 011 add, 100 sub,
//  101 mul, 110 beq, 111 srai) between two requesters: 0 = pipeline EX stage, 1 = aux unit.

---
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Request/result bundle between the two ALU requesters, the result consumer and alu_arbiter.
// master drives requests and consumes results; slave is the arbiter side.
interface alu_arbiter_if #(
  parameter int unsigned TAG_W = 5
) ();
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [31:0]      req0_src1;
  logic [31:0]      req0_src2;
  logic [2:0]       req0_ctrl;
  logic [TAG_W-1:0] req0_tag;
  logic [31:0]      req1_src1;
  logic [31:0]      req1_src2;
  logic [2:0]       req1_ctrl;
  logic [TAG_W-1:0] req1_tag;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;
  logic             res_zero;

  modport master (
    output req_valid, req0_src1, req0_src2, req0_ctrl, req0_tag,
    output req1_src1, req1_src2, req1_ctrl, req1_tag, res_ready,
    input  req_ready, res_valid, res_id, res_tag, res_data, res_zero
  );

  modport slave (
    input  req_valid, req0_src1, req0_src2, req0_ctrl, req0_tag,
    input  req1_src1, req1_src2, req1_ctrl, req1_tag, res_ready,
    output req_ready, res_valid, res_id, res_tag, res_data, res_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU between the EX stage (requester 0) and an aux unit (requester 1), holding the
// ALU for multi-cycle muls. Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_arbiter #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned TAG_W      = 5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  alu_arbiter_if.slave bus,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [2:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i
);

  localparam logic [2:0]  CtrlMul  = 3'b101;
  localparam bit          MulMulti = (MUL_CYCLES > 1);
  localparam int unsigned CntW     = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {StIdle, StMul} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       op_src1_q, op_src1_d;
  logic [31:0]       op_src2_q, op_src2_d;
  logic [2:0]        op_ctrl_q, op_ctrl_d;
  logic [TAG_W-1:0]  op_tag_q, op_tag_d;
  logic              op_id_q, op_id_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic              res_zero_q, res_zero_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;
  logic              res_id_q, res_id_d;

  logic [1:0]        gnt;
  logic [1:0]        tie_gnt;
  logic              can_issue;
  logic              accept;
  logic              sel_id;
  logic [31:0]       sel_src1, sel_src2;
  logic [2:0]        sel_ctrl;
  logic [TAG_W-1:0]  sel_tag;
  logic              sel_is_mul;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tie_gnt = 2'b01;
`else
  logic last_grant_q, last_grant_d;

  // Tie goes to whoever did not win the previous accept.
  assign tie_gnt      = last_grant_q ? 2'b01 : 2'b10;
  assign last_grant_d = accept ? sel_id : last_grant_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  always_comb begin
    gnt = 2'b00;
    unique case (bus.req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = tie_gnt;
      default: gnt = 2'b00;
    endcase
  end

  assign can_issue     = (state_q == StIdle) && (!res_valid_q || bus.res_ready);
  assign bus.req_ready = can_issue ? gnt : 2'b00;
  assign accept        = |bus.req_ready;

  assign sel_id     = gnt[1];
  assign sel_src1   = sel_id ? bus.req1_src1 : bus.req0_src1;
  assign sel_src2   = sel_id ? bus.req1_src2 : bus.req0_src2;
  assign sel_ctrl   = sel_id ? bus.req1_ctrl : bus.req0_ctrl;
  assign sel_tag    = sel_id ? bus.req1_tag  : bus.req0_tag;
  assign sel_is_mul = MulMulti && (sel_ctrl == CtrlMul);

  always_comb begin
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_ctrl_o = '0;
    if (state_q == StMul) begin
      alu_src1_o = op_src1_q;
      alu_src2_o = op_src2_q;
      alu_ctrl_o = op_ctrl_q;
    end else if (|gnt) begin
      alu_src1_o = sel_src1;
      alu_src2_o = sel_src2;
      alu_ctrl_o = sel_ctrl;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_src1_d   = op_src1_q;
    op_src2_d   = op_src2_q;
    op_ctrl_d   = op_ctrl_q;
    op_tag_d    = op_tag_q;
    op_id_d     = op_id_q;
    res_valid_d = res_valid_q && !bus.res_ready;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_tag_d   = res_tag_q;
    res_id_d    = res_id_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (sel_is_mul) begin
            state_d   = StMul;
            cnt_d     = CntW'(MUL_CYCLES - 1);
            op_src1_d = sel_src1;
            op_src2_d = sel_src2;
            op_ctrl_d = sel_ctrl;
            op_tag_d  = sel_tag;
            op_id_d   = sel_id;
          end else begin
            res_valid_d = 1'b1;
            res_data_d  = alu_result_i;
            res_zero_d  = alu_zero_i;
            res_tag_d   = sel_tag;
            res_id_d    = sel_id;
          end
        end
      end
      StMul: begin
        cnt_d = cnt_q - CntW'(1);
        // The result register was emptied when the mul was accepted, so it is free here.
        if (cnt_q == CntW'(1)) begin
          state_d     = StIdle;
          res_valid_d = 1'b1;
          res_data_d  = alu_result_i;
          res_zero_d  = alu_zero_i;
          res_tag_d   = op_tag_q;
          res_id_d    = op_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_src1_q   <= '0;
      op_src2_q   <= '0;
      op_ctrl_q   <= '0;
      op_tag_q    <= '0;
      op_id_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_tag_q   <= '0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_src1_q   <= op_src1_d;
      op_src2_q   <= op_src2_d;
      op_ctrl_q   <= op_ctrl_d;
      op_tag_q    <= op_tag_d;
      op_id_q     <= op_id_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_tag_q   <= res_tag_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_zero  = res_zero_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_id    = res_id_q;

endmodule
